reg_bank: RTL and testbench

- 32 x 32-bit general-purpose register file of the multicycle MIPS datapath.
- Sits directly downstream of mux_wreg: its write_reg input is mux_wreg's data_out, which is one of rt, 29 ($sp), 31 ($ra) or rd.
- Two combinational read ports feed the A/B operand registers.
- One synchronous write port is fed from the write-data mux. A third read-only debug port serves bench and waveform inspection.

---
 rtl/cpu_defs.sv | 22 ++
 rtl/reg_read_port.sv | 39 +++
 rtl/reg_bank.sv | 93 +++++++++
 tb/tb_reg_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared register-file constants for the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam int          NUM_REGS     = 32;
    localparam int          ADDR_W       = 5;
    localparam int          DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_SP_RESET = 32'd227;

    // Write-address constants shared with mux_wreg.
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

`default_nettype wire

// File: rtl/reg_read_port.sv
// ============================================================================
// Module      : reg_read_port
// Description : One combinational register-file read path with r0 forcing
//               and an optional same-cycle write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_read_port
    import cpu_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter bit BYPASS = 1'b1
)
(
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic                            byp_en,
    input  logic [ADDR_W-1:0]               byp_addr,
    input  logic [DATA_W-1:0]               byp_data,
    output logic [DATA_W-1:0]               rd_data
);

    logic w_hit;

    always_comb begin
        w_hit = BYPASS && byp_en && (byp_addr != REG_ZERO) && (byp_addr == rd_addr);
        if (rd_addr == REG_ZERO) begin
            rd_data = '0;
        end else if (w_hit) begin
            rd_data = byp_data;
        end else begin
            rd_data = regs[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
// Module      : reg_bank
// Description : 32 x DATA_W register file, two operand read ports, one
//               synchronous write port and an unbypassed debug read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank
    import cpu_defs::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(DEF_SP_RESET),
    parameter bit                BYPASS   = 1'b1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        dbg_sel,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
    logic [15:0]                     wr_count_q;
    logic [15:0]                     wr_count_d;
    logic                            w_commit;
    logic                            w_byp_en;

    // Writes to r0 are dropped so the stored r0 never leaves zero.
    assign w_commit = reg_write && (write_reg != REG_ZERO);
    assign w_byp_en = reg_write && !reset;

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (w_commit) begin
            regs_d[write_reg] = write_data;
            wr_count_d        = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q         <= '0;
            regs_q[REG_SP] <= SP_RESET;
            wr_count_q     <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    reg_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_port1 (
        .regs     (regs_q),
        .rd_addr  (read_reg1),
        .byp_en   (w_byp_en),
        .byp_addr (write_reg),
        .byp_data (write_data),
        .rd_data  (read_data1)
    );

    reg_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_port2 (
        .regs     (regs_q),
        .rd_addr  (read_reg2),
        .byp_en   (w_byp_en),
        .byp_addr (write_reg),
        .byp_data (write_data),
        .rd_data  (read_data2)
    );

    reg_read_port #(.DATA_W(DATA_W), .BYPASS(1'b0)) u_port_dbg (
        .regs     (regs_q),
        .rd_addr  (dbg_sel),
        .byp_en   (1'b0),
        .byp_addr (write_reg),
        .byp_data (write_data),
        .rd_data  (dbg_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// ============================================================================
// Module      : tb_reg_bank
// Description : Directed bench for reg_bank, bypassed and unbypassed builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  dbg_sel;

    logic [31:0] rd1, rd2, dbg;
    logic [15:0] cnt;
    logic [31:0] nb_rd1, nb_rd2, nb_dbg;
    logic [15:0] nb_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .write_data(write_data), .dbg_sel(dbg_sel),
        .read_data1(rd1), .read_data2(rd2), .dbg_data(dbg), .wr_count(cnt)
    );

    reg_bank #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .write_data(write_data), .dbg_sel(dbg_sel),
        .read_data1(nb_rd1), .read_data2(nb_rd2), .dbg_data(nb_dbg), .wr_count(nb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  ds;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  5'd8,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 16'd1};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        16'd1};
        vecs[2] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd8,  5'd29, 32'hCAFEF00D, 32'hDEADBEEF, 32'd227,      16'd2};
        vecs[3] = '{1'b0, 5'd8,  32'h00000000, 5'd8,  5'd31, 5'd8,  32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 16'd2};
        vecs[4] = '{1'b1, 5'd29, 32'h00000100, 5'd29, 5'd1,  5'd31, 32'h00000100, 32'h0,        32'hCAFEF00D, 16'd3};
        vecs[5] = '{1'b1, 5'd8,  32'h00000011, 5'd8,  5'd8,  5'd8,  32'h00000011, 32'h00000011, 32'h00000011, 16'd4};

        reset = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = '0;
        read_reg1 = 5'd29; read_reg2 = 5'd5; dbg_sel = 5'd29;

        // Reset pulse entirely between clock edges.
        #2 reset = 1'b1;
        #1;
        check("reset_r29_rd1", rd1, 32'd227);
        check("reset_r5_rd2",  rd2, 32'd0);
        check("reset_dbg_r29", dbg, 32'd227);
        check("reset_wr_count", {16'd0, cnt}, 32'd0);
        check("reset_nb_r29",  nb_rd1, 32'd227);
        #1 reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            reg_write  = vecs[i].we;
            write_reg  = vecs[i].wa;
            write_data = vecs[i].wd;
            tick();
            reg_write = 1'b0;
            read_reg1 = vecs[i].r1;
            read_reg2 = vecs[i].r2;
            dbg_sel   = vecs[i].ds;
            #1;
            check($sformatf("vec%0d_rd1", i),    rd1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i),    rd2, vecs[i].e2);
            check($sformatf("vec%0d_dbg", i),    dbg, vecs[i].ed);
            check($sformatf("vec%0d_cnt", i),    {16'd0, cnt}, {16'd0, vecs[i].ec});
            check($sformatf("vec%0d_nb_rd1", i), nb_rd1, vecs[i].e1);
        end

        // Same-cycle bypass on both ports; debug and BYPASS=0 show old r31.
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h00400010;
        read_reg1 = 5'd31; read_reg2 = 5'd31; dbg_sel = 5'd31;
        #1;
        check("byp_rd1",        rd1,    32'h00400010);
        check("byp_rd2",        rd2,    32'h00400010);
        check("byp_dbg_old",    dbg,    32'hCAFEF00D);
        check("nobyp_rd2_old",  nb_rd2, 32'hCAFEF00D);
        tick();
        reg_write = 1'b0;
        #1;
        check("post_byp_rd2",   rd2,    32'h00400010);
        check("post_byp_dbg",   dbg,    32'h00400010);
        check("post_nobyp_rd2", nb_rd2, 32'h00400010);
        check("post_byp_cnt",   {16'd0, cnt}, 32'd5);

        // A write to r0 must not bypass or count.
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        read_reg1 = 5'd0;
        #1;
        check("byp_r0_rd1", rd1, 32'd0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r0_write_cnt", {16'd0, cnt}, 32'd5);

        // Async reset between edges overrides an in-flight write to r29.
        reg_write = 1'b1; write_reg = 5'd29; write_data = 32'd100;
        tick();
        check("r29_100_cnt", {16'd0, cnt}, 32'd6);
        write_data = 32'd5; read_reg1 = 5'd29; read_reg2 = 5'd29; dbg_sel = 5'd29;
        #1;
        check("pre_rst_byp_rd1", rd1, 32'd5);
        check("pre_rst_dbg",     dbg, 32'd100);
        reset = 1'b1;
        #1;
        check("rst_mid_rd1", rd1,    32'd227);
        check("rst_mid_rd2", rd2,    32'd227);
        check("rst_mid_nb",  nb_rd1, 32'd227);
        check("rst_mid_cnt", {16'd0, cnt}, 32'd0);
        reg_write = 1'b0;
        #1 reset = 1'b0;
        tick();
        check("post_rst_r29", rd1, 32'd227);
        dbg_sel = 5'd8;
        #1;
        check("post_rst_r8", dbg, 32'd0);

        // wr_count wrap across 65537 committed writes to r1.
        reg_write = 1'b1; write_reg = 5'd1; read_reg1 = 5'd1;
        for (int i = 1; i <= 65537; i++) begin
            write_data = i;
            tick();
            if (i == 65535) check("cnt_ffff", {16'd0, cnt}, 32'h0000FFFF);
            if (i == 65536) check("cnt_wrap0", {16'd0, cnt}, 32'd0);
        end
        reg_write = 1'b0;
        #1;
        check("wrap_cnt",    {16'd0, cnt},    32'd1);
        check("wrap_nb_cnt", {16'd0, nb_cnt}, 32'd1);
        check("wrap_r1",     rd1,             32'h00010001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
